elevator_call_scheduler: RTL and testbench

Sequences the elevator car between floors. It latches call requests into a pending mask and picks the next target with direction-preserving (SCAN) order. It times inter-floor travel and door dwell, and freezes the car on emergency. It drives the floor-display logic (current floor / next floor) and sits between the call buttons and the display FSM.

---
 rtl/elevator_call_scheduler_pkg.sv | 9 +
 rtl/elevator_call_scheduler_if.sv | 37 +++
 rtl/elevator_call_scheduler_target_picker.sv | 54 +++++
 rtl/elevator_call_scheduler.sv | 135 +++++++++++++
 tb/tb_elevator_call_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and constants for the elevator call scheduler slice.
package elevator_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, DOOR, EMERG} state_e;

    localparam int FLOOR_W_DEF = 4;
    localparam int FLOOR_G     = 0;
    localparam int FLOOR_1     = 1;
    localparam int FLOOR_2     = 2;
endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Call-button / display bundle of the scheduler. door_hold exists only when
// ELEVATOR_DOOR_HOLD_EN is defined.
interface elevator_call_scheduler_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 3,
    parameter int FLOOR_W    = FLOOR_W_DEF
);
    logic [NUM_FLOORS-1:0] call_req;
    logic                  emerg_in;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic                  door_hold;
`endif
    logic [FLOOR_W-1:0]    cur_floor;
    logic [FLOOR_W-1:0]    tgt_floor;
    logic                  moving;
    logic                  dir_up;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;
    logic                  emerg_out;

    modport master (
`ifdef ELEVATOR_DOOR_HOLD_EN
        output door_hold,
`endif
        output call_req, emerg_in,
        input  cur_floor, tgt_floor, moving, dir_up, door_open, pending, emerg_out
    );

    modport slave (
`ifdef ELEVATOR_DOOR_HOLD_EN
        input  door_hold,
`endif
        input  call_req, emerg_in,
        output cur_floor, tgt_floor, moving, dir_up, door_open, pending, emerg_out
    );
endinterface

// File: rtl/elevator_call_scheduler_target_picker.sv
// SCAN target selection: nearest call ahead, then the current floor, then
// the nearest call behind (which implies a direction reversal).
module elevator_target_picker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 3,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    cur_floor_i,
    input  logic                  dir_up_i,
    output logic [FLOOR_W-1:0]    target_o,
    output logic                  found_o,
    output logic                  dir_next_o
);
    logic               up_f, dn_f, here_f;
    logic [FLOOR_W-1:0] up_t, dn_t;

    // Ascending scan: first hit above is nearest up, last hit below is nearest down.
    always_comb begin
        up_f   = 1'b0;
        dn_f   = 1'b0;
        here_f = 1'b0;
        up_t   = cur_floor_i;
        dn_t   = cur_floor_i;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending_i[f]) begin
                if (FLOOR_W'(f) > cur_floor_i && !up_f) begin
                    up_f = 1'b1;
                    up_t = FLOOR_W'(f);
                end
                if (FLOOR_W'(f) < cur_floor_i) begin
                    dn_f = 1'b1;
                    dn_t = FLOOR_W'(f);
                end
                if (FLOOR_W'(f) == cur_floor_i) here_f = 1'b1;
            end
        end
    end

    always_comb begin
        found_o    = up_f | dn_f | here_f;
        target_o   = cur_floor_i;
        dir_next_o = dir_up_i;
        if (dir_up_i ? up_f : dn_f) begin
            target_o = dir_up_i ? up_t : dn_t;
        end else if (here_f) begin
            target_o = cur_floor_i;
        end else if (dir_up_i ? dn_f : up_f) begin
            target_o   = dir_up_i ? dn_t : up_t;
            dir_next_o = ~dir_up_i;
        end
    end
endmodule

// File: rtl/elevator_call_scheduler.sv
// Elevator car sequencer: latches calls, serves them in SCAN order, times
// travel and door dwell, freezes on emergency. Optional: ELEVATOR_DOOR_HOLD_EN.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 3,
    parameter int FLOOR_W       = FLOOR_W_DEF,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input logic                      clk,
    input logic                      reset,
    elevator_call_scheduler_if.slave bus_if
);
    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_e                state_q;
    logic [FLOOR_W-1:0]    cur_q, tgt_q, next_floor, pick_tgt;
    logic                  moving_q, dir_up_q, door_q, emerg_q;
    logic [NUM_FLOORS-1:0] pend_q, pend_d, set_mask, clr_mask;
    logic [CNT_W-1:0]      cnt_q;
    logic                  pick_found, pick_dir;
    logic                  travel_done, arrive, idle_here, retarget, call_here, door_restart;

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        floor_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (f == FLOOR_W'(i)) floor_mask[i] = 1'b1;
    endfunction

    elevator_target_picker #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_picker (
        .pending_i   (pend_q),
        .cur_floor_i (cur_q),
        .dir_up_i    (dir_up_q),
        .target_o    (pick_tgt),
        .found_o     (pick_found),
        .dir_next_o  (pick_dir)
    );

    assign call_here = |(bus_if.call_req & floor_mask(cur_q));
`ifdef ELEVATOR_DOOR_HOLD_EN
    assign door_restart = call_here | bus_if.door_hold;
`else
    assign door_restart = call_here;
`endif

    always_comb begin
        next_floor  = dir_up_q ? cur_q + FLOOR_W'(1) : cur_q - FLOOR_W'(1);
        travel_done = (state_q == MOVE) && (cnt_q == TRAVEL_LAST);
        arrive      = travel_done &&
                      ((next_floor == tgt_q) || |(pend_q & floor_mask(next_floor)));
        idle_here   = (state_q == IDLE) && |pend_q && (pick_tgt == cur_q);
        // While travelling only a closer call in the same direction may retarget.
        retarget    = (state_q == MOVE) && pick_found && (pick_dir == dir_up_q) &&
                      (pick_tgt != cur_q);
        set_mask    = bus_if.call_req;
        if (state_q == DOOR) set_mask = set_mask & ~floor_mask(cur_q);
        clr_mask    = '0;
        if (arrive)         clr_mask = floor_mask(next_floor);
        else if (idle_here) clr_mask = floor_mask(cur_q);
        if (state_q == EMERG || bus_if.emerg_in) pend_d = pend_q;
        else                                     pend_d = (pend_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= FLOOR_W'(FLOOR_G);
            tgt_q    <= FLOOR_W'(FLOOR_G);
            moving_q <= 1'b0;
            dir_up_q <= 1'b1;
            door_q   <= 1'b0;
            pend_q   <= '0;
            emerg_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pend_q <= pend_d;
            if (state_q != EMERG && bus_if.emerg_in) begin
                state_q  <= EMERG;
                moving_q <= 1'b0;
                door_q   <= 1'b0;
                emerg_q  <= 1'b1;
                cnt_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: if (pick_found) begin
                        tgt_q <= pick_tgt;
                        cnt_q <= '0;
                        if (pick_tgt == cur_q) begin
                            state_q <= DOOR;
                            door_q  <= 1'b1;
                        end else begin
                            state_q  <= MOVE;
                            moving_q <= 1'b1;
                            dir_up_q <= pick_dir;
                        end
                    end
                    MOVE: if (travel_done) begin
                        cur_q <= next_floor;
                        cnt_q <= '0;
                        if (arrive) begin
                            state_q  <= DOOR;
                            moving_q <= 1'b0;
                            door_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (retarget) tgt_q <= pick_tgt;
                    end
                    DOOR: if (door_restart) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DOOR_LAST) begin
                        cnt_q   <= '0;
                        door_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus_if.cur_floor = cur_q;
    assign bus_if.tgt_floor = tgt_q;
    assign bus_if.moving    = moving_q;
    assign bus_if.dir_up    = dir_up_q;
    assign bus_if.door_open = door_q;
    assign bus_if.pending   = pend_q;
    assign bus_if.emerg_out = emerg_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (default parameters).
module tb_elevator_call_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;
    logic [14:0] e;

    elevator_call_scheduler_if #(.NUM_FLOORS(3), .FLOOR_W(4)) bus ();

    elevator_call_scheduler #(
        .NUM_FLOORS(3), .FLOOR_W(4), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] snap();
        return {bus.cur_floor, bus.tgt_floor, bus.moving, bus.dir_up, bus.door_open,
                bus.pending, bus.emerg_out};
    endfunction

    function automatic logic [14:0] ev(input int c, input int t, input logic mv,
                                       input logic d, input logic o,
                                       input logic [2:0] p, input logic em);
        return {4'(c), 4'(t), mv, d, o, p, em};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_call(input logic [2:0] c);
        bus.call_req = c;
        tick();
        bus.call_req = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        e = ev(0,0,0,1,0,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL reset_state: got %h want %h", snap(), e); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        pulse_call(3'b100);
        ticks(11);
        e = ev(1,2,1,1,0,3'b100,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL mid_move_pre: got %h want %h", snap(), e); end
        reset = 1'b1;
        #1;
        e = ev(0,0,0,1,0,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL mid_move_async_reset: got %h want %h", snap(), e); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_call();
        do_reset();
        pulse_call(3'b100);
        e = ev(0,0,0,1,0,3'b100,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL call_latency: got %h want %h", snap(), e); end
        tick();
        e = ev(0,2,1,1,0,3'b100,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL move_start: got %h want %h", snap(), e); end
        ticks(7);
        vecs++;
        if (snap() !== e) begin errs++; $display("FAIL before_floor1: got %h want %h", snap(), e); end
        tick();
        e = ev(1,2,1,1,0,3'b100,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL pass_floor1: got %h want %h", snap(), e); end
        ticks(8);
        e = ev(2,2,0,1,1,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL arrive_floor2: got %h want %h", snap(), e); end
        ticks(3);
        vecs++;
        if (snap() !== e) begin errs++; $display("FAIL door_4th_cycle: got %h want %h", snap(), e); end
        tick();
        e = ev(2,2,0,1,0,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL door_closed: got %h want %h", snap(), e); end
    endtask

    task automatic test_intermediate_stop();
        do_reset();
        pulse_call(3'b100);
        tick();
        ticks(3);
        pulse_call(3'b010);
        e = ev(0,2,1,1,0,3'b110,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL mid_call_latched: got %h want %h", snap(), e); end
        tick();
        e = ev(0,1,1,1,0,3'b110,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL retarget_floor1: got %h want %h", snap(), e); end
        ticks(3);
        e = ev(1,1,0,1,1,3'b100,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL stop_floor1: got %h want %h", snap(), e); end
        ticks(4);
        e = ev(1,1,0,1,0,3'b100,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL door1_closed: got %h want %h", snap(), e); end
        tick();
        e = ev(1,2,1,1,0,3'b100,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL resume_to2: got %h want %h", snap(), e); end
        ticks(8);
        e = ev(2,2,0,1,1,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL arrive2_after_stop: got %h want %h", snap(), e); end
    endtask

    task automatic test_scan_order();
        do_reset();
        pulse_call(3'b010);
        tick();
        ticks(8);
        e = ev(1,1,0,1,1,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL scan_at1: got %h want %h", snap(), e); end
        pulse_call(3'b101);
        e = ev(1,1,0,1,1,3'b101,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL scan_latch101: got %h want %h", snap(), e); end
        ticks(4);
        e = ev(1,2,1,1,0,3'b101,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL scan_up_first: got %h want %h", snap(), e); end
        ticks(8);
        e = ev(2,2,0,1,1,3'b001,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL scan_at2: got %h want %h", snap(), e); end
        ticks(5);
        e = ev(2,0,1,0,0,3'b001,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL scan_reverse: got %h want %h", snap(), e); end
        ticks(8);
        e = ev(1,0,1,0,0,3'b001,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL scan_pass1_down: got %h want %h", snap(), e); end
        ticks(8);
        e = ev(0,0,0,0,1,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL scan_at0: got %h want %h", snap(), e); end
    endtask

    task automatic test_emergency();
        do_reset();
        pulse_call(3'b010);
        tick();
        ticks(5);
        bus.emerg_in = 1'b1;
        tick();
        bus.emerg_in = 1'b0;
        e = ev(0,1,0,1,0,3'b010,1); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL emerg_freeze: got %h want %h", snap(), e); end
        bus.call_req = 3'b111;
        ticks(3);
        bus.call_req = 3'b000;
        ticks(10);
        vecs++;
        if (snap() !== e) begin errs++; $display("FAIL emerg_ignores_calls: got %h want %h", snap(), e); end
        reset = 1'b1;
        #1;
        e = ev(0,0,0,1,0,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL emerg_reset_exit: got %h want %h", snap(), e); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_door_at_floor();
        int door_cnt;
        do_reset();
        pulse_call(3'b100);
        tick();
        ticks(20);
        e = ev(2,2,0,1,0,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL idle_at2: got %h want %h", snap(), e); end
        bus.call_req = 3'b100;
        tick();
        e = ev(2,2,0,1,0,3'b100,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL here_latched: got %h want %h", snap(), e); end
        tick();
        e = ev(2,2,0,1,1,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL here_door_open: got %h want %h", snap(), e); end
        ticks(6);
        vecs++;
        if (snap() !== e) begin errs++; $display("FAIL door_held_by_call: got %h want %h", snap(), e); end
        bus.call_req = 3'b000;
        ticks(3);
        vecs++;
        if (snap() !== e) begin errs++; $display("FAIL door_after_release: got %h want %h", snap(), e); end
        tick();
        e = ev(2,2,0,1,0,3'b000,0); vecs++;
        if (snap() !== e) begin errs++; $display("FAIL door_close_after_release: got %h want %h", snap(), e); end
        pulse_call(3'b100);
        tick();
`ifdef ELEVATOR_DOOR_HOLD_EN
        bus.door_hold = 1'b1;
`endif
        door_cnt = 0;
        for (int i = 0; i < 30; i++) begin
`ifdef ELEVATOR_DOOR_HOLD_EN
            if (i == 10) bus.door_hold = 1'b0;
`endif
            if (bus.door_open) door_cnt++;
            tick();
        end
        vecs++;
`ifdef ELEVATOR_DOOR_HOLD_EN
        if (door_cnt != 14) begin errs++; $display("FAIL door_dwell_hold: got %0d want 14", door_cnt); end
`else
        if (door_cnt != 4) begin errs++; $display("FAIL door_dwell: got %0d want 4", door_cnt); end
`endif
    endtask

    initial begin
        bus.call_req = 3'b000;
        bus.emerg_in = 1'b0;
`ifdef ELEVATOR_DOOR_HOLD_EN
        bus.door_hold = 1'b0;
`endif
        test_reset();
        test_reset_mid_move();
        test_single_call();
        test_intermediate_stop();
        test_scan_order();
        test_emergency();
        test_door_at_floor();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
